// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the instruction/data memory arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    OWNER_NONE = 2'd0,
    OWNER_I    = 2'd1,
    OWNER_D    = 2'd2
  } owner_e;

  localparam int LAT_W = 3;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// I-fetch / load-store arbiter for one single-port RAM, one access in flight.
// Define MEM_ARBITER_STATS_EN to add conflict and starvation-event counters.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [31:0]       i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [31:0]       i_rdata,
  input  logic              d_req,
  input  logic [31:0]       d_addr,
  input  logic [3:0]        d_we,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_we,
  output logic [31:0]       mem_d,
  input  logic [31:0]       mem_q
`ifdef MEM_ARBITER_STATS_EN
  ,
  output logic [15:0]       conflict_cnt,
  output logic [15:0]       starve_evt_cnt
`endif
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  logic             busy;
  owner_e           owner;
  logic [LAT_W-1:0] lat_cnt;
  logic [SW-1:0]    starve_cnt;

  logic last;
  logic slot_free;
  logic force_i;
  logic i_win;
  logic d_win;
  logic grant;

  assign last      = busy && (lat_cnt == LAT_W'(1));
  assign slot_free = !busy || last;
  assign force_i   = (starve_cnt == SW'(STARVE_MAX));

  assign i_win = !rst && slot_free && i_req && (!d_req || force_i);
  assign d_win = !rst && slot_free && d_req && !i_win;
  assign grant = i_win || d_win;

  assign i_gnt  = i_win;
  assign d_gnt  = d_win;
  assign mem_en = grant;
  assign mem_we = d_win ? d_we : 4'b0;
  assign mem_d  = grant ? d_wdata : 32'h0;

  always_comb begin
    mem_addr = '0;
    if (d_win)      mem_addr = d_addr[ADDR_W+1:2];
    else if (i_win) mem_addr = i_addr[ADDR_W+1:2];
  end

  assign i_rvalid = !rst && last && (owner == OWNER_I);
  assign d_rvalid = !rst && last && (owner == OWNER_D);
  assign i_rdata  = i_rvalid ? mem_q : 32'h0;
  assign d_rdata  = d_rvalid ? mem_q : 32'h0;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_addr[31:ADDR_W+2], i_addr[1:0],
                              d_addr[31:ADDR_W+2], d_addr[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      busy       <= 1'b0;
      owner      <= OWNER_NONE;
      lat_cnt    <= '0;
      starve_cnt <= '0;
    end else begin
      if (grant) begin
        busy    <= 1'b1;
        owner   <= d_win ? OWNER_D : OWNER_I;
        lat_cnt <= LAT_W'(MEM_LAT);
      end else if (busy) begin
        lat_cnt <= lat_cnt - LAT_W'(1);
        if (last) begin
          busy  <= 1'b0;
          owner <= OWNER_NONE;
        end
      end
      // only counts fetches that actually lost to a data access
      if (i_win)
        starve_cnt <= '0;
      else if (i_req && d_win && !force_i)
        starve_cnt <= starve_cnt + SW'(1);
    end
  end

`ifdef MEM_ARBITER_STATS_EN
  logic [15:0] conflict_q;
  logic [15:0] starve_evt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_q   <= '0;
      starve_evt_q <= '0;
    end else begin
      if (slot_free && i_req && d_req)
        conflict_q <= sat_inc16(conflict_q);
      if (i_win && d_req)
        starve_evt_q <= sat_inc16(starve_evt_q);
    end
  end

  assign conflict_cnt   = rst ? 16'h0 : conflict_q;
  assign starve_evt_cnt = rst ? 16'h0 : starve_evt_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: two instances, MEM_LAT=1 and MEM_LAT=3.
`timescale 1ns/1ps
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [3:0]  d_we;

  logic        i_gnt1, i_rvalid1, d_gnt1, d_rvalid1, mem_en1;
  logic [31:0] i_rdata1, d_rdata1, mem_d1, mem_q1;
  logic [15:0] mem_addr1;
  logic [3:0]  mem_we1;
  logic        i_gnt3, i_rvalid3, d_gnt3, d_rvalid3, mem_en3;
  logic [31:0] i_rdata3, d_rdata3, mem_d3, mem_q3;
  logic [15:0] mem_addr3;
  logic [3:0]  mem_we3;
`ifdef MEM_ARBITER_STATS_EN
  logic [15:0] conf1, sevt1, conf3, sevt3;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(16), .MEM_LAT(1), .STARVE_MAX(4)) u_dut1 (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt1),
    .i_rvalid(i_rvalid1), .i_rdata(i_rdata1),
    .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_wdata(d_wdata),
    .d_gnt(d_gnt1), .d_rvalid(d_rvalid1), .d_rdata(d_rdata1),
    .mem_en(mem_en1), .mem_addr(mem_addr1), .mem_we(mem_we1),
    .mem_d(mem_d1), .mem_q(mem_q1)
`ifdef MEM_ARBITER_STATS_EN
    , .conflict_cnt(conf1), .starve_evt_cnt(sevt1)
`endif
  );

  mem_arbiter #(.ADDR_W(16), .MEM_LAT(3), .STARVE_MAX(4)) u_dut3 (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt3),
    .i_rvalid(i_rvalid3), .i_rdata(i_rdata3),
    .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_wdata(d_wdata),
    .d_gnt(d_gnt3), .d_rvalid(d_rvalid3), .d_rdata(d_rdata3),
    .mem_en(mem_en3), .mem_addr(mem_addr3), .mem_we(mem_we3),
    .mem_d(mem_d3), .mem_q(mem_q3)
`ifdef MEM_ARBITER_STATS_EN
    , .conflict_cnt(conf3), .starve_evt_cnt(sevt3)
`endif
  );

  // RAM models: word w initially holds 32'hA000_0000 | w
  logic [31:0] mem1 [256];
  logic [31:0] mem3 [256];
  logic [31:0] p3 [3];

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem1[i] = 32'hA000_0000 | 32'(i);
      mem3[i] = 32'hA000_0000 | 32'(i);
    end
  end

  always @(posedge clk) begin
    if (mem_en1) begin
      for (int b = 0; b < 4; b++)
        if (mem_we1[b]) mem1[mem_addr1[7:0]][8*b+:8] <= mem_d1[8*b+:8];
      mem_q1 <= mem1[mem_addr1[7:0]];
    end
  end

  always @(posedge clk) begin
    if (mem_en3)
      for (int b = 0; b < 4; b++)
        if (mem_we3[b]) mem3[mem_addr3[7:0]][8*b+:8] <= mem_d3[8*b+:8];
    p3[0] <= mem_en3 ? mem3[mem_addr3[7:0]] : 32'h0;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign mem_q3 = p3[2];

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    i_req = 1'b0; d_req = 1'b0; d_we = 4'h0;
    i_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0;
  endtask

  task automatic do_reset();
    idle_in();
    rst = 1'b1;
    nxt();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    i_req = 1'b1; i_addr = 32'h44; d_req = 1'b1; d_addr = 32'h88;
    d_we = 4'hF; d_wdata = 32'hFFFF_FFFF;
    @(negedge clk);
    n_cmp++; if (i_gnt1 !== 1'b0) begin n_err++; $display("FAIL rst_i_gnt got %h exp 0", i_gnt1); end
    n_cmp++; if (d_gnt1 !== 1'b0) begin n_err++; $display("FAIL rst_d_gnt got %h exp 0", d_gnt1); end
    n_cmp++; if (mem_en1 !== 1'b0) begin n_err++; $display("FAIL rst_mem_en got %h exp 0", mem_en1); end
    n_cmp++; if (mem_we1 !== 4'h0) begin n_err++; $display("FAIL rst_mem_we got %h exp 0", mem_we1); end
    n_cmp++; if (mem_addr1 !== 16'h0) begin n_err++; $display("FAIL rst_mem_addr got %h exp 0", mem_addr1); end
    n_cmp++; if (mem_d1 !== 32'h0) begin n_err++; $display("FAIL rst_mem_d got %h exp 0", mem_d1); end
    n_cmp++; if (d_rdata3 !== 32'h0) begin n_err++; $display("FAIL rst_d_rdata got %h exp 0", d_rdata3); end
    nxt();
    idle_in();
    rst = 1'b0;
    nxt();
  endtask

  task automatic test_fetch_stream();
    i_req = 1'b1; i_addr = 32'h0;
    @(negedge clk);
    n_cmp++; if (i_gnt1 !== 1'b1) begin n_err++; $display("FAIL fetch_gnt0 got %h exp 1", i_gnt1); end
    n_cmp++; if (mem_addr1 !== 16'h0) begin n_err++; $display("FAIL fetch_addr0 got %h exp 0", mem_addr1); end
    n_cmp++; if (i_rvalid1 !== 1'b0) begin n_err++; $display("FAIL fetch_rv0 got %h exp 0", i_rvalid1); end
    nxt();
    i_addr = 32'h4;
    @(negedge clk);
    n_cmp++; if (i_gnt1 !== 1'b1) begin n_err++; $display("FAIL fetch_gnt1 got %h exp 1", i_gnt1); end
    n_cmp++; if (mem_addr1 !== 16'h1) begin n_err++; $display("FAIL fetch_addr1 got %h exp 1", mem_addr1); end
    n_cmp++; if (i_rdata1 !== 32'hA000_0000) begin n_err++; $display("FAIL fetch_data0 got %h exp A0000000", i_rdata1); end
    nxt();
    i_addr = 32'h8;
    @(negedge clk);
    n_cmp++; if (mem_addr1 !== 16'h2) begin n_err++; $display("FAIL fetch_addr2 got %h exp 2", mem_addr1); end
    n_cmp++; if (i_rdata1 !== 32'hA000_0001) begin n_err++; $display("FAIL fetch_data1 got %h exp A0000001", i_rdata1); end
    nxt();
    i_req = 1'b0;
    @(negedge clk);
    n_cmp++; if (mem_en1 !== 1'b0) begin n_err++; $display("FAIL fetch_idle_en got %h exp 0", mem_en1); end
    n_cmp++; if (i_rvalid1 !== 1'b1) begin n_err++; $display("FAIL fetch_rv2 got %h exp 1", i_rvalid1); end
    n_cmp++; if (i_rdata1 !== 32'hA000_0002) begin n_err++; $display("FAIL fetch_data2 got %h exp A0000002", i_rdata1); end
    nxt();
    @(negedge clk);
    n_cmp++; if (i_rdata1 !== 32'h0) begin n_err++; $display("FAIL fetch_rdata_idle got %h exp 0", i_rdata1); end
    nxt();
  endtask

  task automatic test_priority();
    i_req = 1'b1; i_addr = 32'h10; d_req = 1'b1; d_addr = 32'h100;
    @(negedge clk);
    n_cmp++; if (d_gnt1 !== 1'b1 || i_gnt1 !== 1'b0) begin n_err++; $display("FAIL prio_gnt got d=%h i=%h exp d=1 i=0", d_gnt1, i_gnt1); end
    n_cmp++; if (mem_addr1 !== 16'h40) begin n_err++; $display("FAIL prio_daddr got %h exp 40", mem_addr1); end
    nxt();
    d_req = 1'b0;
    @(negedge clk);
    n_cmp++; if (i_gnt1 !== 1'b1) begin n_err++; $display("FAIL prio_igin got %h exp 1", i_gnt1); end
    n_cmp++; if (mem_addr1 !== 16'h4) begin n_err++; $display("FAIL prio_iaddr got %h exp 4", mem_addr1); end
    n_cmp++; if (d_rdata1 !== 32'hA000_0040 || d_rvalid1 !== 1'b1) begin n_err++; $display("FAIL prio_dresp got %h exp A0000040", d_rdata1); end
    n_cmp++; if (i_rvalid1 !== 1'b0) begin n_err++; $display("FAIL prio_irv_early got %h exp 0", i_rvalid1); end
    nxt();
    i_req = 1'b0;
    @(negedge clk);
    n_cmp++; if (i_rdata1 !== 32'hA000_0004 || i_rvalid1 !== 1'b1) begin n_err++; $display("FAIL prio_iresp got %h exp A0000004", i_rdata1); end
    n_cmp++; if (d_rvalid1 !== 1'b0) begin n_err++; $display("FAIL prio_drv_late got %h exp 0", d_rvalid1); end
    nxt();
  endtask

  task automatic test_starvation();
    logic exp_i;
    i_req = 1'b1; i_addr = 32'h20; d_req = 1'b1; d_addr = 32'h200;
    for (int k = 0; k < 6; k++) begin
      exp_i = (k == 4);
      @(negedge clk);
      n_cmp++;
      if (i_gnt1 !== exp_i || d_gnt1 !== !exp_i) begin
        n_err++;
        $display("FAIL starve_gnt%0d got i=%h d=%h exp i=%h d=%h", k, i_gnt1, d_gnt1, exp_i, !exp_i);
      end
      nxt();
    end
    idle_in();
    @(negedge clk);
    n_cmp++; if (d_rdata1 !== 32'hA000_0080) begin n_err++; $display("FAIL starve_dresp got %h exp A0000080", d_rdata1); end
    nxt();
  endtask

  task automatic test_write_lat3();
    do_reset();
    d_req = 1'b1; d_addr = 32'h22; d_we = 4'b0100; d_wdata = 32'h00AB_0000;
    @(negedge clk);
    n_cmp++; if (d_gnt3 !== 1'b1) begin n_err++; $display("FAIL wr_gnt got %h exp 1", d_gnt3); end
    n_cmp++; if (mem_we3 !== 4'b0100) begin n_err++; $display("FAIL wr_we got %h exp 4", mem_we3); end
    n_cmp++; if (mem_addr3 !== 16'h8) begin n_err++; $display("FAIL wr_addr got %h exp 8", mem_addr3); end
    n_cmp++; if (mem_d3 !== 32'h00AB_0000) begin n_err++; $display("FAIL wr_data got %h exp 00AB0000", mem_d3); end
    nxt();
    idle_in();
    i_req = 1'b1; i_addr = 32'h30;
    @(negedge clk);
    n_cmp++; if (i_gnt3 !== 1'b0) begin n_err++; $display("FAIL wr_busy_gnt1 got %h exp 0", i_gnt3); end
    n_cmp++; if (d_rvalid3 !== 1'b0 || d_rdata3 !== 32'h0) begin n_err++; $display("FAIL wr_early_ack got %h exp 0", d_rdata3); end
    nxt();
    @(negedge clk);
    n_cmp++; if (i_gnt3 !== 1'b0 || mem_en3 !== 1'b0) begin n_err++; $display("FAIL wr_busy_gnt2 got %h exp 0", i_gnt3); end
    nxt();
    @(negedge clk);
    n_cmp++; if (d_rvalid3 !== 1'b1) begin n_err++; $display("FAIL wr_ack got %h exp 1", d_rvalid3); end
    n_cmp++; if (i_gnt3 !== 1'b1 || mem_addr3 !== 16'hC) begin n_err++; $display("FAIL wr_ack_igrant got %h/%h exp 1/c", i_gnt3, mem_addr3); end
    nxt();
    i_req = 1'b0;
    nxt();
    nxt();
    @(negedge clk);
    n_cmp++; if (i_rvalid3 !== 1'b1 || i_rdata3 !== 32'hA000_000C) begin n_err++; $display("FAIL lat3_iresp got %h exp A000000C", i_rdata3); end
    nxt();
    d_req = 1'b1; d_addr = 32'h22;
    @(negedge clk);
    n_cmp++; if (d_gnt3 !== 1'b1 || mem_we3 !== 4'h0) begin n_err++; $display("FAIL rb_gnt got %h/%h exp 1/0", d_gnt3, mem_we3); end
    nxt();
    idle_in();
    nxt();
    @(negedge clk);
    n_cmp++; if (d_rvalid3 !== 1'b0) begin n_err++; $display("FAIL rb_early got %h exp 0", d_rvalid3); end
    nxt();
    @(negedge clk);
    n_cmp++; if (d_rvalid3 !== 1'b1 || d_rdata3 !== 32'hA0AB_0008) begin n_err++; $display("FAIL rb_data got %h exp A0AB0008", d_rdata3); end
    nxt();
  endtask

  task automatic test_reset_mid();
    d_req = 1'b1; d_addr = 32'h40;
    @(negedge clk);
    n_cmp++; if (d_gnt3 !== 1'b1) begin n_err++; $display("FAIL rmid_gnt got %h exp 1", d_gnt3); end
    nxt();
    idle_in();
    nxt();
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (d_rvalid3 !== 1'b0) begin n_err++; $display("FAIL rmid_rv_rst got %h exp 0", d_rvalid3); end
    nxt();
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_cmp++; if (d_rvalid3 !== 1'b0) begin n_err++; $display("FAIL rmid_rv%0d got %h exp 0", k, d_rvalid3); end
      nxt();
    end
    i_req = 1'b1; i_addr = 32'h4;
    @(negedge clk);
    n_cmp++; if (i_gnt3 !== 1'b1 || mem_addr3 !== 16'h1) begin n_err++; $display("FAIL rmid_post_gnt got %h/%h exp 1/1", i_gnt3, mem_addr3); end
    nxt();
    i_req = 1'b0;
    nxt();
    nxt();
    @(negedge clk);
    n_cmp++; if (i_rvalid3 !== 1'b1 || i_rdata3 !== 32'hA000_0001) begin n_err++; $display("FAIL rmid_post_data got %h exp A0000001", i_rdata3); end
    nxt();
  endtask

`ifdef MEM_ARBITER_STATS_EN
  task automatic test_stats();
    do_reset();
    i_req = 1'b1; i_addr = 32'h8; d_req = 1'b1; d_addr = 32'h10;
    for (int k = 0; k < 10; k++) nxt();
    idle_in();
    @(negedge clk);
    n_cmp++; if (conf1 !== 16'd10) begin n_err++; $display("FAIL stats_conflict got %0d exp 10", conf1); end
    n_cmp++; if (sevt1 !== 16'd2) begin n_err++; $display("FAIL stats_starve got %0d exp 2", sevt1); end
    nxt();
  endtask
`endif

  initial begin
    rst = 1'b1;
    idle_in();
    test_reset();
    test_fetch_stream();
    test_priority();
    test_starvation();
    test_write_lat3();
    test_reset_mid();
`ifdef MEM_ARBITER_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
